// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester (CPU, DMA) arbiter in front of one
// synchronous single-port RAM. One access in flight at a time:
//   IDLE -> GRANT (memory strobe, winner gnt) -> IDLE for writes
//   IDLE -> GRANT -> RESP (winner rvalid/rdata) -> IDLE for reads
// Build option: define ARB_ROUND_ROBIN_EN to alternate winners on a tie
// (the requester that did not win last time wins); undefined, CPU always
// wins a tie.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU access request (held until cpu_gnt)
//   dma_req/we/addr/wdata    DMA access request (held until dma_gnt)
//   cpu_gnt, dma_gnt         access issued to memory this cycle
//   cpu_rvalid/rdata         CPU read response (rdata is 0 when not valid)
//   dma_rvalid/rdata         DMA read response (rdata is 0 when not valid)
//   mem_en/we/addr/wdata     RAM command, mem_rdata RAM read data (1-cycle)
module mem_port_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          cpu_gnt,
  output logic          dma_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Requester ids
  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DMA = 1'b1;

  state_t        state;
  logic          win_id;      // requester owning the access in flight
  logic          last_grant;  // id of the most recent winner
  logic          cpu_gnt_q;
  logic          dma_gnt_q;
  logic          cpu_rvalid_q;
  logic          dma_rvalid_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          tie_win;
  logic          pick;

  // Tie-break policy
`ifdef ARB_ROUND_ROBIN_EN
  assign tie_win = ~last_grant;
`else
  // CPU always wins; last_grant is tracked but plays no part here
  assign tie_win = ID_CPU & last_grant;
`endif

  // Winner when at least one request is high
  assign pick = cpu_req ? (dma_req ? tie_win : ID_CPU) : ID_DMA;

  // Arbitration FSM; the memory command registers double as the latched
  // request, so input changes after IDLE cannot reach the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      win_id       <= ID_CPU;
      last_grant   <= ID_DMA;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_rvalid_q <= 1'b0;
          dma_rvalid_q <= 1'b0;
          if (cpu_req || dma_req) begin
            state       <= GRANT;
            win_id      <= pick;
            last_grant  <= pick;
            cpu_gnt_q   <= (pick == ID_CPU);
            dma_gnt_q   <= (pick == ID_DMA);
            mem_en_q    <= 1'b1;
            mem_we_q    <= (pick == ID_DMA) ? dma_we    : cpu_we;
            mem_addr_q  <= (pick == ID_DMA) ? dma_addr  : cpu_addr;
            mem_wdata_q <= (pick == ID_DMA) ? dma_wdata : cpu_wdata;
          end
        end
        GRANT: begin
          cpu_gnt_q   <= 1'b0;
          dma_gnt_q   <= 1'b0;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          if (mem_we_q) begin
            state <= IDLE;
          end else begin
            state        <= RESP;
            cpu_rvalid_q <= (win_id == ID_CPU);
            dma_rvalid_q <= (win_id == ID_DMA);
          end
        end
        RESP: begin
          state        <= IDLE;
          cpu_rvalid_q <= 1'b0;
          dma_rvalid_q <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          cpu_gnt_q    <= 1'b0;
          dma_gnt_q    <= 1'b0;
          cpu_rvalid_q <= 1'b0;
          dma_rvalid_q <= 1'b0;
          mem_en_q     <= 1'b0;
          mem_we_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
        end
      endcase
    end
  end

  // Reset blanks every output in the same cycle, so an access caught by
  // reset never shows a gnt or rvalid.
  assign cpu_gnt    = cpu_gnt_q & ~rst;
  assign dma_gnt    = dma_gnt_q & ~rst;
  assign cpu_rvalid = cpu_rvalid_q & ~rst;
  assign dma_rvalid = dma_rvalid_q & ~rst;
  assign mem_en     = mem_en_q & ~rst;
  assign mem_we     = mem_we_q & ~rst;
  assign mem_addr   = mem_addr_q & {AW{~rst}};
  assign mem_wdata  = mem_wdata_q & {DW{~rst}};

  // RAM data arrives in the RESP cycle, so it is steered straight through
  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random access sequences against
// mem_port_arbiter, with a 256-word synchronous RAM attached and a
// reference memory plus winner-selection model kept in the bench.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [256];      // RAM attached to the memory port
  logic [DW-1:0] ref_mem [256];  // expected memory contents
  logic          m_last_dma;     // model: last winner was DMA

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the strobe
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // All handshake outputs quiet
  task automatic chk_quiet(input string tag);
    chk(tag, {59'd0, mem_en, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}, 64'd0);
  endtask

  // Serve one access starting from IDLE with the request inputs already set.
  // Returns 1 when the DUT granted DMA.
  task automatic service(output logic got_dma);
    logic          w_dma;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    // Reference winner from the arbitration rules
    if (cpu_req && dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_dma = ~m_last_dma;
`else
      w_dma = 1'b0;
`endif
    end else begin
      w_dma = dma_req;
    end
    m_last_dma = w_dma;
    we = w_dma ? dma_we    : cpu_we;
    a  = w_dma ? dma_addr  : cpu_addr;
    d  = w_dma ? dma_wdata : cpu_wdata;
    next_cycle();
    // GRANT: winner releases req and scrambles its bus; access must not move
    if (w_dma) begin
      dma_req = 1'b0; dma_addr = dma_addr ^ 32'h20; dma_wdata = ~dma_wdata; dma_we = ~dma_we;
    end else begin
      cpu_req = 1'b0; cpu_addr = cpu_addr ^ 32'h20; cpu_wdata = ~cpu_wdata; cpu_we = ~cpu_we;
    end
    #1;
    got_dma = dma_gnt;
    chk("grant_cpu", 64'(cpu_gnt), 64'(!w_dma));
    chk("grant_dma", 64'(dma_gnt), 64'(w_dma));
    chk("grant_mem_en", 64'(mem_en), 64'd1);
    chk("grant_mem_we", 64'(mem_we), 64'(we));
    chk("grant_mem_addr", 64'(mem_addr), 64'(a));
    if (we) chk("grant_mem_wdata", 64'(mem_wdata), 64'(d));
    chk("grant_no_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'd0);
    next_cycle();
    if (we) begin
      ref_mem[a[7:0]] = d;
      chk_quiet("after_write_idle");
    end else begin
      chk("resp_cpu_rvalid", 64'(cpu_rvalid), 64'(!w_dma));
      chk("resp_dma_rvalid", 64'(dma_rvalid), 64'(w_dma));
      chk("resp_cpu_rdata", 64'(cpu_rdata), w_dma ? 64'd0 : 64'(ref_mem[a[7:0]]));
      chk("resp_dma_rdata", 64'(dma_rdata), w_dma ? 64'(ref_mem[a[7:0]]) : 64'd0);
      chk("resp_quiet_cmd", 64'({mem_en, cpu_gnt, dma_gnt}), 64'd0);
      next_cycle();
      chk_quiet("after_read_idle");
    end
  endtask

  initial begin
    logic g;
    logic [DW-1:0] v;
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end
    ram[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    mem_rdata = '0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (2) next_cycle();
    rst = 1'b0;
    m_last_dma = 1'b1;
    chk_quiet("reset_state");
    chk("reset_mem_bus", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      chk_quiet("idle");
    end

    // CPU read of 0x10; its address moves to 0x30 during GRANT
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    service(g);

    // DMA write 0x20 then CPU read back
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
    service(g);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    service(g);
    chk("readback_model", 64'(ref_mem[8'h20]), 64'h12345678);

    // Reset during the RESP cycle of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    next_cycle();
    cpu_req = 1'b0;
    chk("rst_test_gnt", 64'(cpu_gnt), 64'd1);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("rst_resp_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'd0);
    chk("rst_resp_rdata", 64'(cpu_rdata), 64'd0);
    next_cycle();
    rst = 1'b0;
    m_last_dma = 1'b1;
    chk_quiet("rst_after");
    next_cycle();
    chk_quiet("rst_idle");

    // Both requesters asserting continuously, four writes
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'($urandom_range(0, 255)); cpu_wdata = DW'($urandom);
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = AW'($urandom_range(0, 255)); dma_wdata = DW'($urandom);
`ifdef ARB_ROUND_ROBIN_EN
      service(g);
      chk("contend_order", 64'(g), 64'(i % 2));
`else
      service(g);
      chk("contend_order", 64'(g), 64'd0);
`endif
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    next_cycle();
    chk_quiet("contend_idle");

    // Random traffic; a pending loser keeps its request and payload
    for (int i = 0; i < 30; i++) begin
      if (!cpu_req && ($urandom_range(0, 1) == 1)) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 255)); cpu_wdata = DW'($urandom);
      end
      if (!dma_req && ($urandom_range(0, 1) == 1)) begin
        dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = AW'($urandom_range(0, 255)); dma_wdata = DW'($urandom);
      end
      if (!cpu_req && !dma_req) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 255)); cpu_wdata = DW'($urandom);
      end
      service(g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DW, 32, data width of all data buses.
REQ-002 Parameter AW, 32, address width of all address buses.
REQ-003 Port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Port rst  in  1  reset, synchronous and active-high.
REQ-005 Ports cpu_req/dma_req  in  1  access request; held high until the matching gnt.
REQ-006 Ports cpu_we/dma_we  in  1  1 = write, 0 = read; valid while req is high.
REQ-007 Ports cpu_addr/dma_addr  in  AW  access address; cpu_wdata/dma_wdata  in  DW  write data.
REQ-008 Ports cpu_gnt/dma_gnt  out  1  access issued to memory this cycle.
REQ-009 Ports cpu_rvalid/dma_rvalid  out  1  read data valid; cpu_rdata/dma_rdata  out  DW.
REQ-010 Ports mem_en, mem_we  out  1; mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW (synchronous RAM, read data valid one cycle after mem_en & ~mem_we).

Function
REQ-011 FSM states: IDLE, GRANT, RESP; a single encoding; no other reachable states.
REQ-012 In IDLE with no request the FSM stays in IDLE and all outputs are 0.
REQ-013 In IDLE with at least one request, the FSM selects a winner, latches its we/addr/wdata and requester id, and moves to GRANT.
REQ-014 In GRANT the arbiter drives mem_en=1 and mem_we/addr/wdata from the latched values, with the winner's gnt=1 for exactly one cycle.
REQ-015 From GRANT, a write returns to IDLE and a read moves to RESP.
REQ-016 In RESP the winner's rvalid=1 and its rdata=mem_rdata for exactly one cycle, then the FSM returns to IDLE.
REQ-017 Latency: request sampled in cycle N -> gnt in N+1 -> rvalid (reads) in N+2; throughput is one write per 2 cycles or one read per 3 cycles.
REQ-018 The loser's gnt and rvalid stay 0 throughout; the loser's rdata is 0.
REQ-019 A req, addr or data change after IDLE has no effect on the access in flight.
REQ-020 A requester asserting req in GRANT or RESP is considered only at the next IDLE.
REQ-021 last_grant register: updated to the winner id on IDLE->GRANT.

Reset
REQ-022 rst=1 at a clock edge forces IDLE, clears all outputs to 0, drops any in-flight access (no gnt or rvalid is produced for it), and sets last_grant=DMA.
REQ-023 rst asserted in GRANT or RESP takes priority over every transition.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN defined: if both requests are high in IDLE, the requester not equal to last_grant wins.
REQ-025 Macro ARB_ROUND_ROBIN_EN undefined: CPU always wins a tie (fixed priority); last_grant is still maintained but unused.
REQ-026 With a single requester active, both configurations behave identically.

Verification
REQ-027 After reset, cpu read addr=0x10 with memory[0x10]=0xDEADBEEF -> cpu_gnt at cycle 1, cpu_rvalid and cpu_rdata=0xDEADBEEF at cycle 2, dma outputs 0.
REQ-028 dma write addr=0x20 data=0x12345678, then cpu read addr=0x20 -> dma_gnt with mem_we=1, then cpu_rdata=0x12345678.
REQ-029 Both requesters assert continuously, 4 accesses, ARB_ROUND_ROBIN_EN defined -> grant order CPU, DMA, CPU, DMA; undefined -> CPU x4, dma_gnt stays 0.
REQ-030 rst pulsed in the RESP cycle of a cpu read -> cpu_rvalid=0 that cycle, FSM in IDLE next cycle, mem_en=0.
REQ-031 cpu changes addr 0x10 -> 0x30 in the GRANT cycle -> mem_addr=0x10.
REQ-032 No requests for 10 cycles -> mem_en, both gnt and both rvalid stay 0.
